// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array skew feeder: element defaults,
// the FP16 zero used for bubbles, and the feeder state type.
package sa_pkg;

    localparam int unsigned SA_XLEN_DEFAULT = 16;
    localparam int unsigned SA_N_DEFAULT    = 4;

    localparam logic [15:0] FP16_ZERO = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FEED  = 2'd2,
        ST_FLUSH = 2'd3
    } sa_state_e;

endpackage

// File: rtl/sa_skew_line.sv
// Fixed-length register delay line with synchronous clear; one instance per
// array row or column produces that lane's skew.
module sa_skew_line
    import sa_pkg::*;
#(
    parameter int unsigned XLEN  = SA_XLEN_DEFAULT,
    parameter int unsigned DEPTH = 1
) (
    input  logic            clk,
    input  logic            clr_i,
    input  logic [XLEN-1:0] d_i,
    output logic [XLEN-1:0] q_o
);

    logic [XLEN-1:0] tap_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                tap_q[k] <= '0;
            end
        end else begin
            tap_q[0] <= d_i;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                tap_q[k] <= tap_q[k-1];
            end
        end
    end

    assign q_o = tap_q[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// Feeds k-slices of A and B into an NxN systolic array with per-lane skew,
// sequences accumulator clear, and signals when the array results are final.
module sa_skew_feeder
    import sa_pkg::*;
#(
    parameter int unsigned XLEN = SA_XLEN_DEFAULT,
    parameter int unsigned N    = SA_N_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    input  logic [N*XLEN-1:0] s_a,
    input  logic [N*XLEN-1:0] s_b,
    output logic [N*XLEN-1:0] west_o,
    output logic [N*XLEN-1:0] north_o,
    output logic              arr_clr,
    output logic              busy,
    output logic              done
);

    localparam int unsigned     CW         = $clog2(2 * N);
    localparam logic [CW-1:0]   FLUSH_LOAD = CW'(2 * N - 1);

    sa_state_e         state_q;
    logic [CW-1:0]     cnt_q;
    logic              ready_q;
    logic              busy_q;
    logic              clr_q;
    logic              done_q;

    logic [N*XLEN-1:0] inj_a_d;
    logic [N*XLEN-1:0] inj_b_d;
    logic [N*XLEN-1:0] west_w;
    logic [N*XLEN-1:0] north_w;

    // Outputs are registered alongside the state so they track it exactly;
    // done is raised on the edge that brings the flush count to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                        clr_q   <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state_q <= ST_FEED;
                    clr_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
                ST_FEED: begin
                    if (s_valid && s_last) begin
                        state_q <= ST_FLUSH;
                        ready_q <= 1'b0;
                        cnt_q   <= FLUSH_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q - CW'(1);
                        done_q <= (cnt_q == CW'(1));
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Anything not accepted in FEED enters the skew lines as zeros.
    always_comb begin
        inj_a_d = {N{XLEN'(FP16_ZERO)}};
        inj_b_d = {N{XLEN'(FP16_ZERO)}};
        if (state_q == ST_FEED && s_valid) begin
            inj_a_d = s_a;
            inj_b_d = s_b;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        sa_skew_line #(
            .XLEN  (XLEN),
            .DEPTH (g + 1)
        ) u_west (
            .clk   (clk),
            .clr_i (rst),
            .d_i   (inj_a_d[g*XLEN +: XLEN]),
            .q_o   (west_w[g*XLEN +: XLEN])
        );

        sa_skew_line #(
            .XLEN  (XLEN),
            .DEPTH (g + 1)
        ) u_north (
            .clk   (clk),
            .clr_i (rst),
            .d_i   (inj_b_d[g*XLEN +: XLEN]),
            .q_o   (north_w[g*XLEN +: XLEN])
        );
    end

    // Reset forces the edge outputs quiet and holds the array clear for as
    // long as it is asserted, not only from the first reset edge onward.
    assign west_o  = rst ? '0 : west_w;
    assign north_o = rst ? '0 : north_w;
    assign s_ready = ready_q & ~rst;
    assign busy    = busy_q  & ~rst;
    assign done    = done_q  & ~rst;
    assign arr_clr = clr_q   |  rst;

endmodule
